cascade_counter_fsm: RTL and testbench
======================================

// Module: cascade_counter_fsm
// PURPOSE
//  Parametrised cascaded-digit counter/sequencer benchmark for the iscas89 app set; successor to the fixed
//  gate-level counter/controller circuits. STAGES digits of modulo-MODULUS counters, with a 4-state control FSM,
//  synchronous clear, up/down counting, a valid/ready preload port and a terminal-count pulse.
//  Instantiated standalone as a mapped application on generated fabrics.
// PARAMETERS
//  WIDTH    4   bits per digit
//  STAGES   3   number of cascaded digits (>=1)
//  MODULUS  16  digit modulus, 2..2**WIDTH (10 = BCD)
// PORTS
//  clk       in   1              rising-edge clock
//  rst_n     in   1              asynchronous active-low reset
//  clr       in   1              synchronous clear, highest priority
//  start     in   1              IDLE->RUN request
//  pause     in   1              RUN<->PAUSE level control
//  dir       in   1              1=count up, 0=count down; sampled every counting cycle
//  ld_valid  in   1              preload request
//  ld_data   in   WIDTH*STAGES   preload value; digit i at [i*WIDTH +: WIDTH], digit 0 = LSD
//  ld_ready  out  1              preload accepted when ld_valid&ld_ready
//  count_o   out  WIDTH*STAGES   current count, registered
//  tc_o      out  1              one-cycle terminal-count pulse, registered
//  state_o   out  2              IDLE=00 RUN=01 PAUSE=10 DONE=11
// BEHAVIOUR
//  - Reset (rst_n low, async): count_o=0, tc_o=0, state_o=IDLE. ld_ready=1 (comb from state).
//  - ld_ready = (state==IDLE || state==PAUSE) && !clr.
//  - clr=1: next cycle count_o=0, state IDLE, tc_o=0. Overrides every other input.
//  - Load: on accept, count_o<=ld_data with each digit >MODULUS-1 clamped to MODULUS-1. State is unchanged,
//    except in IDLE with start=1: load and go RUN in the same edge. Counting starts on the next cycle.
//  - IDLE: start=1 -> RUN. count held.
//  - RUN, pause=1: -> PAUSE, count held that cycle.
//  - RUN, pause=0:
//      - if count == terminal (all digits MODULUS-1 when dir=1; all digits 0 when dir=0): -> DONE, tc_o<=1,
//        count held.
//      - else step by 1 in direction dir. Digit i steps only when all lower digits are at MODULUS-1 (up) or 0
//        (down). Each digit wraps MODULUS-1<->0. Carry/borrow ripples combinationally within one cycle.
//  - PAUSE: pause=0 -> RUN. Load is allowed here.
//  - DONE: lasts exactly one cycle; tc_o=1 during it; then -> IDLE with tc_o=0. start is ignored in DONE.
//  - tc_o is 0 in every state except DONE.
//  - dir changed mid-RUN takes effect on the next step; no glitch in count_o.
//  - Reset mid-operation: async clear to reset values; no partial state survives.
// CONFIGURATION
//  CASCADE_COUNTER_AUTORELOAD_EN
//    defined: terminal in RUN does not enter DONE. count_o<=last accepted ld_data (clamped; 0 if none since
//      reset/clr), state stays RUN, tc_o pulses 1 cycle. clr also zeroes the reload register.
//    undefined: RUN->DONE->IDLE as above; no reload register is built.
// TESTING (WIDTH=4 STAGES=2 MODULUS=10 unless noted)
//  1. Reset then idle 3 cycles -> count_o=0x00, state_o=00, tc_o=0, ld_ready=1.
//  2. Load 0x98 + start, dir=1 -> c1 count=0x99, c2 state=11 tc_o=1, c3 state=00 tc_o=0, count=0x99.
//  3. Load 0x10, dir=0, start -> 0x09 (digit-0 borrow wraps 0->9), continue to 0x00, then DONE pulse.
//  4. ld_data=0xFC -> count_o=0x99 (both digits clamped). In RUN, ld_valid=1 -> ld_ready=0, no load.
//  5. RUN at 0x45, pause 3 cycles -> held 0x45, state=10. Load 0x70 in PAUSE -> 0x70. Release -> 0x71.
//     clr mid-RUN -> 0x00, IDLE. rst_n pulse mid-RUN -> immediate reset values.
//  6. AUTORELOAD_EN defined, load 0x97, dir=1, start -> 0x98, 0x99, then tc_o=1 with count=0x97 and state=01.

Source files
------------

// File: rtl/cascade_counter_fsm.sv
// Cascaded modulo-MODULUS digit counter with a 4-state control FSM, preload port and terminal-count pulse.
// Optional feature macro: CASCADE_COUNTER_AUTORELOAD_EN (terminal in RUN reloads the last preload value).
//
// Handshake: a preload is accepted on a rising edge where ld_valid && ld_ready. ld_ready depends only on
// state and clr, never on ld_valid, so the producer may hold ld_valid/ld_data until it sees ld_ready.
module cascade_counter_fsm #(
    parameter int WIDTH   = 4,
    parameter int STAGES  = 3,
    parameter int MODULUS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      dir,
    input  logic                      ld_valid,
    input  logic [WIDTH*STAGES-1:0]   ld_data,
    output logic                      ld_ready,
    output logic [WIDTH*STAGES-1:0]   count_o,
    output logic                      tc_o,
    output logic [1:0]                state_o
);

    localparam int CW = WIDTH * STAGES;
    localparam logic [WIDTH-1:0] DMAX = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              tc_q, tc_d;
    logic [CW-1:0]     count_step;
    logic [CW-1:0]     ld_clamped;
    logic [STAGES-1:0] dig_max;
    logic [STAGES-1:0] dig_zero;
    logic [STAGES-1:0] en_up;
    logic [STAGES-1:0] en_dn;
    logic              at_term;
    logic              ld_accept;
    logic              counting;

    // Per-digit compare, clamp and single-step datapath.
    for (genvar g = 0; g < STAGES; g++) begin : g_digit
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] ld_dig;
        assign cur      = count_q[g*WIDTH +: WIDTH];
        assign ld_dig   = ld_data[g*WIDTH +: WIDTH];
        assign dig_max[g]  = (cur == DMAX);
        assign dig_zero[g] = (cur == '0);
        assign ld_clamped[g*WIDTH +: WIDTH] = (ld_dig > DMAX) ? DMAX : ld_dig;

        always_comb begin
            count_step[g*WIDTH +: WIDTH] = cur;
            if (dir) begin
                if (en_up[g]) begin
                    count_step[g*WIDTH +: WIDTH] = dig_max[g] ? '0 : cur + WIDTH'(1);
                end
            end else begin
                if (en_dn[g]) begin
                    count_step[g*WIDTH +: WIDTH] = dig_zero[g] ? DMAX : cur - WIDTH'(1);
                end
            end
        end
    end

    // Digit i moves only when every lower digit sits at its wrap point for the current direction.
    always_comb begin
        en_up[0] = 1'b1;
        en_dn[0] = 1'b1;
        for (int i = 1; i < STAGES; i++) begin
            en_up[i] = en_up[i-1] & dig_max[i-1];
            en_dn[i] = en_dn[i-1] & dig_zero[i-1];
        end
    end

    assign at_term = dir ? (&dig_max) : (&dig_zero);

`ifdef CASCADE_COUNTER_AUTORELOAD_EN
    logic [CW-1:0] reload_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else if (clr) begin
            reload_q <= '0;
        end else if (ld_accept) begin
            reload_q <= ld_clamped;
        end
    end
`endif

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A load in PAUSE keeps PAUSE for that edge; only IDLE+start may load and leave.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (at_term) begin
`ifdef CASCADE_COUNTER_AUTORELOAD_EN
                        state_d = S_RUN;
`else
                        state_d = S_DONE;
`endif
                    end
                end
                S_PAUSE: begin
                    if (!ld_accept && !pause) state_d = S_RUN;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM: outputs decoded from state.
    always_comb begin
        ld_ready = ((state_q == S_IDLE) || (state_q == S_PAUSE)) && !clr;
        counting = (state_q == S_RUN) && !pause && !clr;
        state_o  = state_q;
    end

    assign ld_accept = ld_valid && ld_ready;

    // Count/terminal datapath next value: clr, then load, then counting.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (ld_accept) begin
            count_d = ld_clamped;
        end else if (counting) begin
            if (at_term) begin
                tc_d = 1'b1;
`ifdef CASCADE_COUNTER_AUTORELOAD_EN
                count_d = reload_q;
`endif
            end else begin
                count_d = count_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule

// File: tb/tb_cascade_counter_fsm.sv
// Bench for cascade_counter_fsm (WIDTH=4 STAGES=2 MODULUS=10): vector table, corner sequences, random vs model.
module tb_cascade_counter_fsm;

    localparam int W     = 4;
    localparam int S     = 2;
    localparam int M     = 10;
    localparam int CW    = W * S;
    localparam int TOTAL = 100;

    logic          clk = 1'b0;
    logic          rst_n, clr, start, pause, dir, ld_valid;
    logic [CW-1:0] ld_data;
    logic          ld_ready, tc_o;
    logic [CW-1:0] count_o;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];

    // Reference model: count as a plain integer 0..TOTAL-1, state as the published 2-bit code.
    int ms, mv, mrel;
    bit mtc;

    cascade_counter_fsm #(.WIDTH(W), .STAGES(S), .MODULUS(M)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .pause(pause), .dir(dir),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .count_o(count_o), .tc_o(tc_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic st, input logic p, input logic d,
                         input logic v, input logic [CW-1:0] data);
        clr = c; start = st; pause = p; dir = d; ld_valid = v; ld_data = data;
    endtask

    task automatic quiet();
        drive(1'b0, 1'b0, 1'b0, dir, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [CW-1:0] c, input logic [1:0] st, input logic tc);
        check({tag, " count"}, 32'(count_o), 32'(c));
        check({tag, " state"}, 32'(state_o), 32'(st));
        check({tag, " tc"},    32'(tc_o),    32'(tc));
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ms = 0; mv = 0; mrel = 0; mtc = 1'b0;
    endtask

    function automatic int clamp_val(input logic [CW-1:0] d);
        int v = 0;
        int p = 1;
        for (int i = 0; i < S; i++) begin
            int dg = int'(d[i*W +: W]);
            if (dg > M - 1) dg = M - 1;
            v += dg * p;
            p *= M;
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] to_digits(input int v);
        logic [CW-1:0] r = '0;
        int x = v;
        for (int i = 0; i < S; i++) begin
            r[i*W +: W] = W'(x % M);
            x = x / M;
        end
        return r;
    endfunction

    function automatic bit model_ready();
        return (ms == 0 || ms == 2) && !clr;
    endfunction

    task automatic model_step();
        bit acc = ld_valid && model_ready();
        mtc = 1'b0;
        if (clr) begin
            mv = 0; ms = 0; mrel = 0;
        end else if (acc) begin
            mv = clamp_val(ld_data);
            mrel = mv;
            if (ms == 0 && start) ms = 1;
        end else begin
            case (ms)
                0: if (start) ms = 1;
                1: begin
                    if (pause) ms = 2;
                    else if (dir ? (mv == TOTAL - 1) : (mv == 0)) begin
                        mtc = 1'b1;
`ifdef CASCADE_COUNTER_AUTORELOAD_EN
                        mv = mrel;
`else
                        ms = 3;
`endif
                    end else begin
                        mv = dir ? (mv + 1) % TOTAL : (mv + TOTAL - 1) % TOTAL;
                    end
                end
                2: if (!pause) ms = 1;
                default: ms = 0;
            endcase
        end
    endtask

    typedef struct {
        logic          c, st, p, d, v;
        logic [CW-1:0] data;
        logic [CW-1:0] e_cnt;
        logic [1:0]    e_st;
        logic          e_tc, e_rdy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h98, 8'h98, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 2'b11, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 2'b00, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFC, 8'h99, 2'b00, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h98, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 2'b00, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 2'b01, 1'b0, 1'b0};

        do_reset();

        // Reset then idle.
        repeat (3) tick();
        expect_out("reset", 8'h00, 2'b00, 1'b0);
        check("reset ld_ready", 32'(ld_ready), 32'd1);

`ifndef CASCADE_COUNTER_AUTORELOAD_EN
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].c, tbl[i].st, tbl[i].p, tbl[i].d, tbl[i].v, tbl[i].data);
            tick();
            quiet();
            #1;
            expect_out($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_st, tbl[i].e_tc);
            check($sformatf("vec%0d ld_ready", i), 32'(ld_ready), 32'(tbl[i].e_rdy));
        end
`endif

        // Count down from 0x10 through the digit-0 borrow to zero.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10); tick();
        quiet(); dir = 1'b0;
        expect_out("down load", 8'h10, 2'b01, 1'b0);
        for (int k = 9; k >= 0; k--) begin
            tick();
            check($sformatf("down %0d", k), 32'(count_o), 32'(to_digits(k)));
        end
        tick();
`ifdef CASCADE_COUNTER_AUTORELOAD_EN
        expect_out("down reload", 8'h10, 2'b01, 1'b1);
`else
        expect_out("down done", 8'h00, 2'b11, 1'b1);
        tick();
        expect_out("down idle", 8'h00, 2'b00, 1'b0);
`endif

        // Pause/hold, load in PAUSE, release, clr and async reset mid-RUN.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44); tick();
        quiet(); dir = 1'b1;
        tick();
        check("run 45", 32'(count_o), 32'h45);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out($sformatf("pause%0d", k), 8'h45, 2'b10, 1'b0);
        end
        check("pause ld_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1; ld_data = 8'h70;
        tick();
        ld_valid = 1'b0;
        expect_out("pause load", 8'h70, 2'b10, 1'b0);
        pause = 1'b0;
        tick();
        expect_out("release", 8'h70, 2'b01, 1'b0);
        tick();
        expect_out("resume", 8'h71, 2'b01, 1'b0);
        clr = 1'b1; ld_valid = 1'b1;
        #1 check("clr ld_ready", 32'(ld_ready), 32'd0);
        tick();
        quiet();
        expect_out("clr run", 8'h00, 2'b00, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("pre-reset count", 32'(count_o), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        expect_out("async reset", 8'h00, 2'b00, 1'b0);
        check("async reset ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        tick();

`ifdef CASCADE_COUNTER_AUTORELOAD_EN
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h97); tick();
        quiet(); dir = 1'b1;
        expect_out("ar load", 8'h97, 2'b01, 1'b0);
        tick(); expect_out("ar 98", 8'h98, 2'b01, 1'b0);
        tick(); expect_out("ar 99", 8'h99, 2'b01, 1'b0);
        tick(); expect_out("ar wrap", 8'h97, 2'b01, 1'b1);
        tick(); expect_out("ar next", 8'h98, 2'b01, 1'b0);
`endif

        // Randomized run against the integer model.
        do_reset();
        dir = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            clr      = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 3) == 0);
            pause    = ($urandom_range(0, 11) == 0);
            ld_valid = ($urandom_range(0, 9) == 0);
            ld_data  = CW'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) dir = ~dir;
            #1;
            check("rand ld_ready", 32'(ld_ready), 32'(model_ready()));
            model_step();
            exp_q.push_back(to_digits(mv));
            tick();
            check("rand count", 32'(count_o), 32'(exp_q.pop_front()));
            check("rand state", 32'(state_o), 32'(ms));
            check("rand tc", 32'(tc_o), 32'(mtc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
